return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Hardware return-address stack directly upstream of the program counter.
- On a CALL it stores the return address.
- On a RET it presents the popped address together with the one-cycle pop strobe and write-enable the program counter consumes: address into the PC `in`, strobe into `STACK_POP`, write-enable into `w`.
- Also reports occupancy and sticky overflow/underflow error flags.

Parameters:
- DEPTH, 16, number of return-address entries; power of two, at least 2.
- AW, 16, address width; matches the PC width.

Ports:
- clk  input  1  system clock; all state updates on the falling edge, aligned with the PC.
- rst  input  1  asynchronous active-low reset.
- push  input  1  CALL request; sampled on falling edge.
- pop  input  1  RET request; sampled on falling edge.
- flush  input  1  synchronous clear of all entries; error flags are preserved.
- clr_err  input  1  synchronous clear of the sticky error flags.
- push_addr  input  AW  return address to store (CALL site + 1, supplied by decode).
- ret_addr  output  AW  popped return address, driven to the PC `in`.
- ret_pop  output  1  one-cycle strobe, driven to the PC `STACK_POP`.
- ret_wr  output  1  one-cycle write-enable, driven to the PC `w`; identical to ret_pop.
- count  output  $clog2(DEPTH+1)  current number of valid entries.
- empty  output  1  count == 0; combinational from count.
- full  output  1  count == DEPTH; combinational from count.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- Reset (rst low, asynchronous, any time including mid-operation):
  - count=0, ret_addr=0, ret_pop=0, ret_wr=0, overflow=0, underflow=0.
  - empty=1, full=0.
  - Entry RAM contents are don't-care.
- Storage and pointer:
  - DEPTH x AW register array; stack pointer sp = count.
  - Top-of-stack entry is mem[sp-1].
- Priority per falling edge: flush > simultaneous push+pop > pop > push > idle.
- flush:
  - count becomes 0; ret_pop and ret_wr are 0 that cycle.
  - Any push/pop sampled on the same edge is ignored.
- pop alone, count>0:
  - ret_addr <= mem[sp-1]; ret_pop, ret_wr <= 1; count <= count-1.
  - Latency: ret_addr and strobe are visible from this falling edge until the next one (one cycle), so the PC loads the value on the following falling edge.
- pop alone, count==0:
  - underflow <= 1; ret_pop stays 0; ret_addr holds its previous value; count unchanged.
- push alone, count<DEPTH:
  - mem[sp] <= push_addr; count <= count+1.
- push alone, count==DEPTH:
  - overflow <= 1; write dropped; count unchanged.
  - No wrap-around: the oldest entry is never overwritten.
- push and pop together (tail-call/replace), count>0:
  - ret_addr <= old mem[sp-1]; ret_pop <= 1.
  - mem[sp-1] <= push_addr; count unchanged.
- push and pop together, count==0:
  - Treated as pop on empty (underflow <= 1, no strobe), then push succeeds: mem[0] <= push_addr, count <= 1.
- ret_pop/ret_wr:
  - Never high for two consecutive cycles unless pop is held high with entries available.
  - Default 0 on every edge without a successful pop.
- clr_err: clears overflow and underflow. A new error event on the same edge wins, so the flag is set.
- Arithmetic: count is unsigned and never exceeds DEPTH or goes below 0. Push data is stored unmodified, with no +1 applied internally.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, ret_pop=0, ret_addr=0000, flags 0.
- Push 0x0011, 0x0022, 0x0033; pop x3 on consecutive cycles -> ret_addr 0x0033, 0x0022, 0x0011, each with a 1-cycle ret_pop; count 3->0; empty=1 at end.
- Push 16 distinct values (0x0100..0x010F), then push 0xBEEF -> full=1, overflow=1, count=16; 16 pops return 0x010F..0x0100 with no 0xBEEF.
- Pop on empty -> underflow=1, ret_pop=0, ret_addr unchanged; clr_err -> underflow=0.
- Push 0x0040, then push 0x0050 with pop on the same edge -> ret_addr=0x0040 with ret_pop=1, count=1; next pop returns 0x0050.
- Push 0x0A0A x2, assert rst low asynchronously between clock edges -> outputs zero immediately; after release, pop -> underflow=1. Separately, push 2 entries then flush -> count=0 and flags unchanged.

Source files
------------

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
//
// Hardware return-address stack that sits directly upstream of the program
// counter. A CALL pushes the return address. A RET pops it and presents it to
// the PC together with a one-cycle load strobe. All state changes on the
// falling clock edge, in step with the PC.
//
// Parameters
//   DEPTH  number of return-address entries (power of two, >= 2)
//   AW     address width (matches the PC width)
//
// Ports
//   clk        system clock; state updates on the falling edge
//   rst        asynchronous reset, active low
//   push       CALL request
//   pop        RET request
//   flush      synchronous clear of all entries (error flags kept)
//   clr_err    synchronous clear of the sticky error flags
//   push_addr  return address to store (already CALL site + 1)
//   ret_addr   popped return address, to the PC data input
//   ret_pop    one-cycle strobe, to the PC STACK_POP input
//   ret_wr     one-cycle write-enable, to the PC w input (same as ret_pop)
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was rejected because the stack was full
//   underflow  sticky: a pop was rejected because the stack was empty
// ---------------------------------------------------------------------------
module return_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic [AW-1:0]              push_addr,
    output logic [AW-1:0]              ret_addr,
    output logic                       ret_pop,
    output logic                       ret_wr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];

    logic [PW-1:0] top_idx;   // entry at sp-1 (only meaningful when count > 0)
    logic [PW-1:0] wr_idx;    // free slot at sp (only meaningful when not full)
    logic          mem_we;
    logic [PW-1:0] mem_widx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = PW'(count - CW'(1));
    assign wr_idx  = PW'(count);

    // The PC takes the same strobe as both its pop and write-enable inputs.
    assign ret_wr = ret_pop;

    // A simultaneous push+pop on a non-empty stack replaces the top entry in
    // place; on an empty stack it degenerates to an ordinary push into slot 0,
    // which is wr_idx at that point.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = wr_idx;
        if (!flush && push) begin
            if (pop && !empty) begin
                mem_we   = 1'b1;
                mem_widx = top_idx;
            end else if (pop || !full) begin
                mem_we   = 1'b1;
                mem_widx = wr_idx;
            end
        end
    end

    // Entry storage carries no reset; contents are don't-care until written.
    always_ff @(negedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= push_addr;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            ret_addr  <= '0;
            ret_pop   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ret_pop <= 1'b0;

            // Clear first so that an error raised on the same edge wins.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end

            if (flush) begin
                count <= '0;
            end else if (push && pop) begin
                if (!empty) begin
                    ret_addr <= mem[top_idx];
                    ret_pop  <= 1'b1;
                end else begin
                    underflow <= 1'b1;
                    count     <= CW'(1);
                end
            end else if (pop) begin
                if (!empty) begin
                    ret_addr <= mem[top_idx];
                    ret_pop  <= 1'b1;
                    count    <= count - CW'(1);
                end else begin
                    underflow <= 1'b1;
                end
            end else if (push) begin
                if (!full) begin
                    count <= count + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// ---------------------------------------------------------------------------
// tb_return_stack
//
// Directed testbench for return_stack (DEPTH=16, AW=16). Inputs change just
// after each falling edge and outputs are observed 1 time unit after the
// falling edge on which the DUT updated.
// ---------------------------------------------------------------------------
module tb_return_stack;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        flush;
    logic        clr_err;
    logic [15:0] push_addr;
    logic [15:0] ret_addr;
    logic        ret_pop;
    logic        ret_wr;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int nvec;
    int nerr;

    return_stack #(.DEPTH(16), .AW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .clr_err   (clr_err),
        .push_addr (push_addr),
        .ret_addr  (ret_addr),
        .ret_pop   (ret_pop),
        .ret_wr    (ret_wr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of requests across a single falling edge, then go idle.
    task automatic cyc(input logic p, input logic q, input logic f,
                       input logic c, input logic [15:0] a);
        push      = p;
        pop       = q;
        flush     = f;
        clr_err   = c;
        push_addr = a;
        @(negedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    // Status word: {count, empty, full, ret_pop, ret_wr, overflow, underflow}
    task automatic test_reset();
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; push_addr = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 16'h0);
        nvec++;
        if ({count, empty, full, ret_pop, ret_wr, overflow, underflow} !== 11'b00000_1_0_0_0_0_0) begin
            nerr++;
            $display("FAIL reset_status got %b want %b",
                     {count, empty, full, ret_pop, ret_wr, overflow, underflow}, 11'b00000_1_0_0_0_0_0);
        end
        nvec++;
        if (ret_addr !== 16'h0000) begin
            nerr++; $display("FAIL reset_addr got %h want 0000", ret_addr);
        end
    endtask

    task automatic test_lifo();
        cyc(1, 0, 0, 0, 16'h0011);
        cyc(1, 0, 0, 0, 16'h0022);
        cyc(1, 0, 0, 0, 16'h0033);
        nvec++;
        if (count !== 5'd3) begin nerr++; $display("FAIL lifo_count got %0d want 3", count); end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, ret_wr, count} !== {16'h0033, 1'b1, 1'b1, 5'd2}) begin
            nerr++; $display("FAIL lifo_pop1 got %h/%b%b/%0d want 0033/11/2", ret_addr, ret_pop, ret_wr, count);
        end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, count} !== {16'h0022, 1'b1, 5'd1}) begin
            nerr++; $display("FAIL lifo_pop2 got %h/%b/%0d want 0022/1/1", ret_addr, ret_pop, count);
        end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, count, empty} !== {16'h0011, 1'b1, 5'd0, 1'b1}) begin
            nerr++; $display("FAIL lifo_pop3 got %h/%b/%0d/%b want 0011/1/0/1", ret_addr, ret_pop, count, empty);
        end
        cyc(0, 0, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, ret_wr, underflow} !== {16'h0011, 1'b0, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL lifo_idle got %h/%b%b/%b want 0011/00/0", ret_addr, ret_pop, ret_wr, underflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, 16'(16'h0100 + i));
        nvec++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL ovf_fill got %0d/%b/%b want 16/1/0", count, full, overflow);
        end
        cyc(1, 0, 0, 0, 16'hBEEF);
        nvec++;
        if ({count, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
            nerr++; $display("FAIL ovf_reject got %0d/%b/%b want 16/1/1", count, full, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0, 16'h0);
            nvec++;
            if ({ret_addr, ret_pop, count} !== {16'(16'h010F - i), 1'b1, 5'(15 - i)}) begin
                nerr++; $display("FAIL ovf_drain%0d got %h/%b/%0d want %h/1/%0d",
                                 i, ret_addr, ret_pop, count, 16'(16'h010F - i), 15 - i);
            end
        end
        cyc(0, 0, 0, 1, 16'h0);
        nvec++;
        if ({overflow, empty, full} !== 3'b010) begin
            nerr++; $display("FAIL ovf_clr got %b want 010", {overflow, empty, full});
        end
    endtask

    task automatic test_underflow();
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, underflow, count} !== {16'h0100, 1'b0, 1'b1, 5'd0}) begin
            nerr++; $display("FAIL udf_pop got %h/%b/%b/%0d want 0100/0/1/0", ret_addr, ret_pop, underflow, count);
        end
        // Error raised on the same edge as clr_err must remain set.
        cyc(0, 1, 0, 1, 16'h0);
        nvec++;
        if (underflow !== 1'b1) begin nerr++; $display("FAIL udf_clr_race got %b want 1", underflow); end
        cyc(0, 0, 0, 1, 16'h0);
        nvec++;
        if (underflow !== 1'b0) begin nerr++; $display("FAIL udf_clr got %b want 0", underflow); end
    endtask

    task automatic test_replace();
        cyc(1, 0, 0, 0, 16'h0040);
        cyc(1, 1, 0, 0, 16'h0050);
        nvec++;
        if ({ret_addr, ret_pop, ret_wr, count} !== {16'h0040, 1'b1, 1'b1, 5'd1}) begin
            nerr++; $display("FAIL repl_swap got %h/%b%b/%0d want 0040/11/1", ret_addr, ret_pop, ret_wr, count);
        end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, count} !== {16'h0050, 1'b1, 5'd0}) begin
            nerr++; $display("FAIL repl_pop got %h/%b/%0d want 0050/1/0", ret_addr, ret_pop, count);
        end
        // push+pop on empty: underflow, no strobe, push still lands in slot 0
        cyc(1, 1, 0, 0, 16'h0077);
        nvec++;
        if ({ret_addr, ret_pop, underflow, count} !== {16'h0050, 1'b0, 1'b1, 5'd1}) begin
            nerr++; $display("FAIL repl_empty got %h/%b/%b/%0d want 0050/0/1/1", ret_addr, ret_pop, underflow, count);
        end
        cyc(0, 1, 0, 1, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, underflow, count} !== {16'h0077, 1'b1, 1'b0, 5'd0}) begin
            nerr++; $display("FAIL repl_empty_pop got %h/%b/%b/%0d want 0077/1/0/0", ret_addr, ret_pop, underflow, count);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 16'h1234);
        cyc(1, 0, 0, 0, 16'h5678);
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop} !== {16'h5678, 1'b1}) begin
            nerr++; $display("FAIL b2b_pop1 got %h/%b want 5678/1", ret_addr, ret_pop);
        end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, count} !== {16'h1234, 1'b1, 5'd0}) begin
            nerr++; $display("FAIL b2b_pop2 got %h/%b/%0d want 1234/1/0", ret_addr, ret_pop, count);
        end
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, underflow} !== {16'h1234, 1'b0, 1'b1}) begin
            nerr++; $display("FAIL b2b_pop3 got %h/%b/%b want 1234/0/1", ret_addr, ret_pop, underflow);
        end
        cyc(0, 0, 0, 1, 16'h0);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0, 16'h0A0A);
        cyc(1, 0, 0, 0, 16'h0A0A);
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_addr, ret_pop, count} !== {16'h0A0A, 1'b1, 5'd1}) begin
            nerr++; $display("FAIL arst_pre got %h/%b/%0d want 0A0A/1/1", ret_addr, ret_pop, count);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2 rst = 1'b0;
        #1;
        nvec++;
        if ({ret_addr, ret_pop, ret_wr, count, empty, full} !== {16'h0000, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL arst_now got %h/%b%b/%0d/%b%b want 0000/00/0/10",
                             ret_addr, ret_pop, ret_wr, count, empty, full);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_pop, underflow, count} !== {1'b0, 1'b1, 5'd0}) begin
            nerr++; $display("FAIL arst_pop got %b/%b/%0d want 0/1/0", ret_pop, underflow, count);
        end
    endtask

    // underflow is left set from test_async_reset to show flush preserves it.
    task automatic test_flush();
        cyc(1, 0, 0, 0, 16'h0101);
        cyc(1, 0, 0, 0, 16'h0202);
        nvec++;
        if (count !== 5'd2) begin nerr++; $display("FAIL flush_pre got %0d want 2", count); end
        cyc(1, 1, 1, 0, 16'h0303);
        nvec++;
        if ({count, empty, ret_pop, underflow, overflow} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL flush got %0d/%b/%b/%b/%b want 0/1/0/1/0", count, empty, ret_pop, underflow, overflow);
        end
        cyc(0, 0, 0, 1, 16'h0);
        cyc(0, 1, 0, 0, 16'h0);
        nvec++;
        if ({ret_pop, underflow, count} !== {1'b0, 1'b1, 5'd0}) begin
            nerr++; $display("FAIL flush_post got %b/%b/%0d want 0/1/0", ret_pop, underflow, count);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_back_to_back();
        test_async_reset();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
